sdivseq: RTL
============

// Module: sdivseq
// PURPOSE
//  Sequential signed integer divider; the inverse of the signed multiply-accumulate datapath.
//  Computes quotient and remainder of da / db, truncating toward zero, one quotient bit per cycle (restoring).
//  Valid/ready on both sides. Sits in the arithmetic library beside the multiplier blocks; used for normalisation and scaling.
// PARAMETERS
//  NWIDTH  8  dividend and quotient width, signed, >= 2
//  DWIDTH  8  divisor and remainder width, signed, 2..NWIDTH
// PORTS
//  clk        in   1       clock, rising edge
//  sclr       in   1       reset, synchronous, active-high
//  clken      in   1       clock enable; low freezes all state
//  in_valid   in   1       operands valid
//  in_ready   out  1       divider can accept operands
//  da         in   NWIDTH  dividend, signed
//  db         in   DWIDTH  divisor, signed
//  out_valid  out  1       result valid
//  out_ready  in   1       downstream accepts result
//  quot       out  NWIDTH  quotient, signed
//  rem        out  DWIDTH  remainder, signed, same sign as dividend (or zero)
//  div0       out  1       divide-by-zero flag for the current result
//  ovf        out  1       overflow flag (most-negative / -1)
// BEHAVIOUR
//  - Single clock domain, one synchronous active-high reset. Reset wins over clken.
//  - Reset: state IDLE, in_ready=1 (if clken), out_valid=0, quot='0, rem='0, div0=0, ovf=0.
//  - clken=0: no register updates. in_ready and out_valid are gated by clken, so no transfer happens.
//  - Input transfer: in_valid & in_ready & clken at a rising edge. Output transfer: out_valid & out_ready & clken.
//  - FSM: IDLE -> CALC on an input transfer. The block latches |da|, |db|, the sign of da, and sign(da)^sign(db).
//    CALC runs NWIDTH enabled cycles, one restoring step per cycle, MSB first. The bit counter runs NWIDTH-1 down to 0.
//    CALC -> FIX when the counter reaches 0. FIX applies sign correction and flags (1 cycle).
//    FIX -> DONE. DONE holds out_valid=1 and stable outputs until an output transfer, then returns to IDLE.
//  - Latency: out_valid rises NWIDTH+2 enabled cycles after the input transfer edge. It is uniform for all operands, including div0 and ovf.
//  - in_ready=1 only in IDLE. There is no overlap: throughput is one op per NWIDTH+3 cycles minimum.
//  - The datapath is unsigned with magnitudes of width NWIDTH+1 (abs(-2^(NWIDTH-1)) must be representable).
//    The partial remainder register is DWIDTH+1 bits wide.
//  - Sign fix: quot = qneg ? -q : q; rem = dneg ? -r : r. Results are truncated to their port widths.
//  - db==0: quot = all ones (-1), rem = '0, div0=1, ovf=0. The datapath result is discarded.
//  - da==-2^(NWIDTH-1) with db==-1: quot = -2^(NWIDTH-1) (wraps), rem=0, ovf=1, div0=0.
//  - |da| < |db|: quot=0, rem=da (fits DWIDTH by construction). da==0: quot=0, rem=0.
//  - quot, rem, div0 and ovf change only on the FIX->DONE edge. They hold their last result in IDLE.
//  - sclr mid-CALC/FIX/DONE aborts the operation. No out_valid follows for the aborted op.
//  - in_valid while busy is ignored (in_ready=0). The upstream must hold its operands.
// STRUCTURE
//  - Package smath_pkg: typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} sdiv_state_t.
//    It also holds the function sabs(): signed to unsigned of width+1, and the function clog2-based counter width helper.
//  - One sub-module, sdiv_step: a combinational single restoring step.
//    Inputs: partial remainder, next dividend bit, |divisor|. Outputs: new remainder, quotient bit.
//    Instantiated once, registered in sdivseq.
//  - Top holds the FSM, bit counter, operand/quotient shift register, sign fix and flag logic.
// TESTING (NWIDTH=DWIDTH=8, out_ready=1 unless stated)
//  - Sign quadrants: 100/7 -> 14 r2; -100/7 -> -14 r-2; 100/-7 -> -14 r2; -100/-7 -> 14 r-2. Each shows out_valid 10 cycles after accept.
//  - Divide by zero: 5/0 -> quot=8'hFF, rem=0, div0=1, ovf=0, same 10-cycle latency.
//  - Overflow: -128/-1 -> quot=-128, rem=0, ovf=1. Also -128/1 -> -128 r0 with no flags, and -128/127 -> -1 r-1.
//  - Back-pressure and handshake: hold out_ready=0 for 5 cycles with outputs stable; in_ready=0 throughout.
//    An in_valid pulse during the op is ignored. After the output transfer, in_ready=1 the next cycle.
//  - clken: toggle clken every other cycle during 50/3. Expect latency of 10 enabled cycles and result 16 r2.
//  - Reset mid-CALC: assert sclr at cycle 4. Expect out_valid=0, outputs zero, and in_ready=1 the cycle after release.
//    A following 9/4 -> 2 r1.

Source files
------------

// File: rtl/smath_pkg.sv
// Shared types and helpers for the signed arithmetic blocks.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: sdiv_state_t divider FSM encoding, sabs() magnitude helper,
//           cnt_width() bit-counter width helper.
package smath_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} sdiv_state_t;

  // Widest operand the helpers accept. Callers sign-extend into this width.
  localparam int SMAX = 32;

  // Signed to unsigned magnitude, one bit wider so that |most-negative| fits.
  function automatic logic [SMAX:0] sabs(input logic signed [SMAX-1:0] v);
    logic [SMAX:0] e;
    e = {v[SMAX-1], v};
    return v[SMAX-1] ? -e : e;
  endfunction

  // Width of a down-counter that must hold n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdiv_step.sv
// One restoring division step: shift in the next dividend bit, subtract if it fits.
// Latency: combinational.
// Backpressure: none; registered by the caller.
// Ports: prem (partial remainder), nbit (next dividend bit), dmag (|divisor|)
//        -> rem_nxt (new partial remainder), qbit (quotient bit).
module sdiv_step
  import smath_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic [DWIDTH:0] prem,
  input  logic            nbit,
  input  logic [DWIDTH:0] dmag,
  output logic [DWIDTH:0] rem_nxt,
  output logic            qbit
);

  logic [DWIDTH+1:0] trial;
  logic [DWIDTH:0]   diff;

  assign trial = {prem, nbit};
  assign qbit  = (trial >= {1'b0, dmag});
  // When the subtraction succeeds the result is below dmag, so the low bits suffice.
  assign diff    = trial[DWIDTH:0] - dmag;
  assign rem_nxt = qbit ? diff : trial[DWIDTH:0];

endmodule

// File: rtl/sdivseq.sv
// Sequential signed divider (restoring, one quotient bit per cycle), truncating toward zero.
// Latency: out_valid NWIDTH+2 enabled cycles after the accepting cycle, for every operand.
// Backpressure: single op in flight; in_ready only when idle, result held until out_ready.
// Ports: clk, sclr (sync, active-high), clken (freezes all state);
//        in_valid/in_ready with da (dividend), db (divisor);
//        out_valid/out_ready with quot, rem, div0 (divisor zero), ovf (min / -1).
module sdivseq
  import smath_pkg::*;
#(
  parameter int NWIDTH = 8,
  parameter int DWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     sclr,
  input  logic                     clken,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [NWIDTH-1:0] da,
  input  logic signed [DWIDTH-1:0] db,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [NWIDTH-1:0] quot,
  output logic signed [DWIDTH-1:0] rem,
  output logic                     div0,
  output logic                     ovf
);

  localparam int CW = cnt_width(NWIDTH);
  localparam logic [SMAX:0] AMIN = (SMAX+1)'(1) << (NWIDTH-1);

  sdiv_state_t     state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [NWIDTH-1:0] qsr;      // dividend magnitude shifts out, quotient bits shift in
  logic [DWIDTH:0] prem, prem_nxt, dmag;
  logic            qbit, qneg, dneg, zdiv, oflow;
  logic [SMAX:0]   amag_w, dmag_w;

  assign amag_w = sabs(SMAX'(da));
  assign dmag_w = sabs(SMAX'(db));

  sdiv_step #(.DWIDTH(DWIDTH)) u_step (
    .prem    (prem),
    .nbit    (qsr[NWIDTH-1]),
    .dmag    (dmag),
    .rem_nxt (prem_nxt),
    .qbit    (qbit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (sclr)       state <= IDLE;
    else if (clken) state <= state_nxt;
  end

  // Next state; only applied on enabled edges, so raw valid/ready act as transfers.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:                    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs, gated by clken so nothing transfers on frozen cycles.
  always_comb begin
    in_ready  = clken & (state == IDLE);
    out_valid = clken & (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (sclr) begin
      cnt   <= '0;
      qsr   <= '0;
      prem  <= '0;
      dmag  <= '0;
      qneg  <= 1'b0;
      dneg  <= 1'b0;
      zdiv  <= 1'b0;
      oflow <= 1'b0;
      quot  <= '0;
      rem   <= '0;
      div0  <= 1'b0;
      ovf   <= 1'b0;
    end else if (clken) begin
      unique case (state)
        IDLE: if (in_valid) begin
          cnt   <= CW'(NWIDTH-1);
          qsr   <= amag_w[NWIDTH-1:0];   // |da| <= 2^(NWIDTH-1) always fits NWIDTH bits
          prem  <= '0;
          dmag  <= dmag_w[DWIDTH:0];
          qneg  <= da[NWIDTH-1] ^ db[DWIDTH-1];
          dneg  <= da[NWIDTH-1];
          zdiv  <= (dmag_w == '0);
          oflow <= (amag_w == AMIN) && (dmag_w == (SMAX+1)'(1)) && db[DWIDTH-1];
        end
        CALC: begin
          prem <= prem_nxt;
          qsr  <= {qsr[NWIDTH-2:0], qbit};
          cnt  <= cnt - 1'b1;
        end
        FIX: begin
          if (zdiv) begin
            quot <= '1;
            rem  <= '0;
          end else if (oflow) begin
            quot <= {1'b1, {(NWIDTH-1){1'b0}}};
            rem  <= '0;
          end else begin
            quot <= qneg ? -qsr : qsr;
            // Final remainder is below |db| <= 2^(DWIDTH-1), so DWIDTH bits hold it.
            rem  <= dneg ? -prem[DWIDTH-1:0] : prem[DWIDTH-1:0];
          end
          div0 <= zdiv;
          ovf  <= oflow;
        end
        default: ;
      endcase
    end
  end

endmodule
